// File: rtl/fp_pkg.sv
// fp_pkg: shared types and helpers for the float multiplier datapath.
// Operand class encoding, flag bundle layout, bias and qNaN builders.
package fp_pkg;

  localparam int FP_MAX_W = 64;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(
    input int ew,
    input int mw
  );
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (((one << ew) - one) << mw) | (one << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational operand classifier for the float multiplier.
// Ports: word in; sign, expo, sig (hidden bit included), cls out.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output logic [1:0]           cls
);

  logic [MAN_W-1:0] frac;
  fp_class_t        c;

  assign sign = word[EXP_W+MAN_W];
  assign expo = word[EXP_W+MAN_W-1:MAN_W];
  assign frac = word[MAN_W-1:0];

  // Subnormals are flushed: they classify as zero and keep their sign.
  always_comb begin
    c   = FP_NORM;
    sig = {1'b1, frac};
    if (expo == '0) begin
      c   = FP_ZERO;
      sig = '0;
    end else if (&expo) begin
      if (frac == '0) begin
        c = FP_INF;
      end else begin
        c = FP_NAN;
      end
    end
  end

  assign cls = c;

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754-style multiplier, RNE, valid/ready.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/product/flags.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FP_W  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] product,
  output logic [3:0]      flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * SW;

  localparam logic signed [EW2-1:0] BIAS =
    EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EMAX =
    EW2'((1 << EXP_W) - 1);
  localparam logic [FP_W-1:0] QNAN =
    FP_W'(fp_qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic                  sign;
    fp_class_t             cls;
    logic signed [EW2-1:0] expo;
    logic [SW-1:0]         siga;
    logic [SW-1:0]         sigb;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    fp_class_t             cls;
    logic signed [EW2-1:0] expo;
    logic [PW-1:0]         prod;
  } s2_t;

  logic adv;
  logic take;

  // One shared enable: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [SW-1:0]    ma, mb;
  logic [1:0]       ca_w, cb_w;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_a (
    .word (a),
    .sign (sa),
    .expo (ea),
    .sig  (ma),
    .cls  (ca_w)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_b (
    .word (b),
    .sign (sb),
    .expo (eb),
    .sig  (mb),
    .cls  (cb_w)
  );

  fp_class_t ca, cb;
  s1_t       s1_d, s1_q;
  logic      s1_v;
  s2_t       s2_d, s2_q;
  logic      s2_v;

  // The result class folds both operands with NaN > inf > zero priority.
  always_comb begin
    ca        = fp_class_t'(ca_w);
    cb        = fp_class_t'(cb_w);
    s1_d      = '0;
    s1_d.sign = sa ^ sb;
    s1_d.expo = $signed({2'b00, ea})
              + $signed({2'b00, eb}) - BIAS;
    s1_d.siga = ma;
    s1_d.sigb = mb;
    if (ca == FP_NAN || cb == FP_NAN ||
        (ca == FP_INF && cb == FP_ZERO) ||
        (ca == FP_ZERO && cb == FP_INF)) begin
      s1_d.cls = FP_NAN;
    end else if (ca == FP_INF || cb == FP_INF) begin
      s1_d.cls = FP_INF;
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      s1_d.cls = FP_ZERO;
    end else begin
      s1_d.cls = FP_NORM;
    end
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.cls  = s1_q.cls;
    s2_d.expo = s1_q.expo;
    s2_d.prod = PW'(s1_q.siga) * PW'(s1_q.sigb);
  end

  logic                  msb, guard, sticky;
  logic                  lsb, inc, carry;
  logic [PW-1:0]         norm;
  logic [SW-1:0]         keep;
  logic [SW:0]           rnd;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] efin;
  logic                  ovf, unf;
  logic [FP_W-1:0]       res;
  fp_flags_t             fl, flags_q;

  // Product lies in [1,4): left-align so the leading 1 sits at the MSB.
  always_comb begin
    msb    = s2_q.prod[PW-1];
    norm   = msb ? s2_q.prod : (s2_q.prod << 1);
    keep   = norm[PW-1:MAN_W+1];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    lsb    = keep[0];
    inc    = guard && (sticky || lsb);
    rnd    = {1'b0, keep} + (SW+1)'(inc);
    carry  = rnd[SW];
    frac   = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    efin   = s2_q.expo
           + $signed({{(EW2-1){1'b0}}, msb})
           + $signed({{(EW2-1){1'b0}}, carry});
    ovf    = (efin >= EMAX);
    unf    = efin[EW2-1] || (efin == '0);
    res    = '0;
    fl     = '0;
    unique case (s2_q.cls)
      FP_NAN: begin
        res        = QNAN;
        fl.invalid = 1'b1;
      end
      FP_INF: begin
        res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      FP_ZERO: begin
        res = {s2_q.sign, {(FP_W-1){1'b0}}};
      end
      default: begin
        if (ovf) begin
          res         = {s2_q.sign, {EXP_W{1'b1}},
                         {MAN_W{1'b0}}};
          fl.overflow = 1'b1;
          fl.inexact  = 1'b1;
        end else if (unf) begin
          res          = {s2_q.sign, {(FP_W-1){1'b0}}};
          fl.underflow = 1'b1;
          fl.inexact   = 1'b1;
        end else begin
          res        = {s2_q.sign, efin[EXP_W-1:0], frac};
          fl.inexact = guard || sticky;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_q      <= '0;
      s2_v      <= 1'b0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      product   <= '0;
      flags_q   <= '0;
    end else if (adv) begin
      s1_v <= take;
      if (take) begin
        s1_q <= s1_d;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_q <= s2_d;
      end
      out_valid <= s2_v;
      if (s2_v) begin
        product <= res;
        flags_q <= fl;
      end
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: self-checking bench for the pipelined multiplier.
// Directed vectors plus randomized traffic against a value-level model.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  fp_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Exact product as an integer significand times a power of two,
  // then rounded by comparing the discarded remainder with one half.
  function automatic void ref_mul(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] r,
    output logic [3:0]  f
  );
    int ex, ey, n, sh, e;
    bit s, zx, zy, ix, iy, nx, ny;
    longint unsigned mx, my, p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 32'h7FC0_0000;
      f = 4'b1000;
      return;
    end
    if (ix || iy) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0000;
      return;
    end
    if (zx || zy) begin
      r = {s, 31'd0};
      f = 4'b0000;
      return;
    end
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    p  = mx * my;
    n  = 0;
    for (int i = 0; i < 64; i++)
      if (((p >> i) & 64'd1) != 0) n = i;
    sh   = n - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ex + ey - 127 + n - 46;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0101;
    end else if (e <= 0) begin
      r = {s, 31'd0};
      f = 4'b0011;
    end else begin
      r = {s, e[7:0], q[22:0]};
      f = {3'b000, rem != 0};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    logic [7:0] e;
    sel = $urandom_range(9, 0);
    case (sel)
      0: begin
        case ($urandom_range(7, 0))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'h7F80_0000;
          3: return 32'hFF80_0000;
          4: return 32'h7FC0_0000;
          5: return 32'h7F80_0001;
          6: return 32'h0000_0001;
          default: return 32'h8040_0000;
        endcase
      end
      1, 2, 3, 4, 5, 6: begin
        e = 8'($urandom_range(190, 64));
        return {1'($urandom), e, 23'($urandom)};
      end
      7: begin
        e = 8'($urandom_range(254, 1));
        return {1'($urandom), e, 23'($urandom)};
      end
      default: return $urandom;
    endcase
  endfunction

  // One operation through an idle pipe with the consumer always ready.
  task automatic do_op(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] p,
    output logic [3:0]  f,
    output bit          ok
  );
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    p  = product;
    f  = flags;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    total++;
    if (product !== 32'h0) begin
      bad++;
      $display("FAIL reset_product got=%h want=0", product);
    end
    total++;
    if (flags !== 4'h0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", flags);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h4000_0000;
    b = 32'h3F80_0000;
    @(negedge clk);
    a = 32'hC040_0000;
    b = 32'hC000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_early got=%b want=0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || product !== 32'h4000_0000 ||
        flags !== 4'h0) begin
      bad++;
      $display("FAIL b2b_first v=%b p=%h f=%b want 1 40000000 0000",
               out_valid, product, flags);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || product !== 32'h40C0_0000 ||
        flags !== 4'h0) begin
      bad++;
      $display("FAIL b2b_second v=%b p=%h f=%b want 1 40c00000 0000",
               out_valid, product, flags);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b want=0", out_valid);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [2], vb [2], vp [2];
    logic [3:0]  vf [2];
    logic [31:0] p;
    logic [3:0]  f;
    bit          ok;
    va = '{32'h40FC_0000, 32'h3F80_0001};
    vb = '{32'h3E40_0000, 32'h3F80_0001};
    vp = '{32'h3FBD_0000, 32'h3F80_0002};
    vf = '{4'b0000, 4'b0001};
    for (int i = 0; i < 2; i++) begin
      do_op(va[i], vb[i], p, f, ok);
      total++;
      if (!ok || p !== vp[i] || f !== vf[i]) begin
        bad++;
        $display("FAIL arith[%0d] ok=%0d p=%h f=%b want %h %b",
                 i, ok, p, f, vp[i], vf[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [3], vb [3], vp [3];
    logic [3:0]  vf [3];
    logic [31:0] p;
    logic [3:0]  f;
    bit          ok;
    va = '{32'h7F80_0000, 32'h7FC0_0001, 32'hFF80_0000};
    vb = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000};
    vp = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000};
    vf = '{4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], p, f, ok);
      total++;
      if (!ok || p !== vp[i] || f !== vf[i]) begin
        bad++;
        $display("FAIL special[%0d] ok=%0d p=%h f=%b want %h %b",
                 i, ok, p, f, vp[i], vf[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] va [3], vb [3], vp [3];
    logic [3:0]  vf [3];
    logic [31:0] p;
    logic [3:0]  f;
    bit          ok;
    va = '{32'h7F00_0000, 32'h0080_0000, 32'h8000_0001};
    vb = '{32'h7F00_0000, 32'h3F00_0000, 32'h3F80_0000};
    vp = '{32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};
    vf = '{4'b0101, 4'b0011, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], p, f, ok);
      total++;
      if (!ok || p !== vp[i] || f !== vf[i]) begin
        bad++;
        $display("FAIL range[%0d] ok=%0d p=%h f=%b want %h %b",
                 i, ok, p, f, vp[i], vf[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] xa [4], xb [4];
    logic [35:0] q [$];
    logic [35:0] e;
    logic [31:0] r, hold_p;
    logic [3:0]  f;
    int          idx, got, taken_stalled;
    bit          saw_block, hold_v;
    idx = 0;
    got = 0;
    taken_stalled = 0;
    saw_block = 0;
    hold_v = 0;
    hold_p = '0;
    for (int i = 0; i < 4; i++) begin
      xa[i] = {1'b0, 8'(120 + i), 23'($urandom)};
      xb[i] = {1'($urandom), 8'(130 - i), 23'($urandom)};
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hold_v) begin
        total++;
        if (product !== hold_p || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL bp_hold v=%b p=%h want 1 %h",
                   out_valid, product, hold_p);
        end
      end
      if (c == 6) taken_stalled = idx;
      out_ready = (c >= 6);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        a = xa[idx];
        b = xb[idx];
      end
      #1;
      if (c < 6 && !in_ready) saw_block = 1;
      if (in_valid && in_ready) begin
        ref_mul(a, b, r, f);
        q.push_back({f, r});
        idx++;
      end
      if (out_valid && out_ready) begin
        total++;
        got++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra p=%h want none", product);
        end else begin
          e = q.pop_front();
          if ({flags, product} !== e) begin
            bad++;
            $display("FAIL bp_order p=%h f=%b want %h %b",
                     product, flags, e[31:0], e[35:32]);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_p = product;
    end
    in_valid = 1'b0;
    total++;
    if (!saw_block || taken_stalled != 3) begin
      bad++;
      $display("FAIL bp_ready blocked=%0d taken=%0d want 1 3",
               saw_block, taken_stalled);
    end
    total++;
    if (got != 4 || idx != 4) begin
      bad++;
      $display("FAIL bp_count got=%0d sent=%0d want 4 4", got, idx);
    end
  endtask

  task automatic test_reset_flight();
    logic [31:0] p;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h4000_0000;
    b = 32'h4000_0000;
    @(negedge clk);
    a = 32'h4040_0000;
    b = 32'h4040_0000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || product !== 32'h0 ||
        flags !== 4'h0) begin
      bad++;
      $display("FAIL rf_clear v=%b p=%h f=%b want 0 0 0",
               out_valid, product, flags);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rf_ready got=%b want=1", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rf_stale cyc=%0d p=%h want no valid", c, product);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    p = product;
    total++;
    if (out_valid !== 1'b1 || p !== 32'h40C0_0000 ||
        flags !== 4'h0) begin
      bad++;
      $display("FAIL rf_next v=%b p=%h f=%b want 1 40c00000 0000",
               out_valid, p, flags);
    end
  endtask

  task automatic test_random();
    logic [35:0] q [$];
    logic [35:0] e;
    logic [31:0] r, hold_p;
    logic [3:0]  f, hold_f;
    bit          hold_v;
    hold_v = 0;
    hold_p = '0;
    hold_f = '0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (hold_v) begin
        total++;
        if (out_valid !== 1'b1 || product !== hold_p ||
            flags !== hold_f) begin
          bad++;
          $display("FAIL rnd_hold v=%b p=%h f=%b want 1 %h %b",
                   out_valid, product, flags, hold_p, hold_f);
        end
      end
      out_ready = (c >= 400) || ($urandom_range(9, 0) < 7);
      in_valid  = (c < 400) && ($urandom_range(3, 0) != 0);
      a = rand_op();
      b = rand_op();
      #1;
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL rnd_ready got=%b v=%b r=%b",
                 in_ready, out_valid, out_ready);
      end
      if (in_valid && in_ready) begin
        ref_mul(a, b, r, f);
        q.push_back({f, r});
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra p=%h want none", product);
        end else begin
          e = q.pop_front();
          if ({flags, product} !== e) begin
            bad++;
            $display("FAIL rnd_result p=%h f=%b want %h %b",
                     product, flags, e[31:0], e[35:32]);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_p = product;
      hold_f = flags;
    end
    in_valid = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_lost pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0;
    test_reset();
    test_back_to_back();
    test_arith();
    test_special();
    test_range();
    test_backpressure();
    test_reset_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
